mem_stage_ctrl: RTL and testbench

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

---
 rtl/mem_stage_ctrl_pkg.sv | 76 +++++++
 rtl/mem_lane_gen.sv | 51 +++++
 rtl/mem_stage_ctrl.sv | 130 +++++++++++++
 tb/tb_mem_stage_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_ctrl_pkg.sv
// Shared pipeline definitions: opcode/funct encodings, W-stage load codes,
// forwarding latencies and the instruction decoder used by the M stage.
package mem_stage_ctrl_pkg;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_JAL   = 6'h03;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_LUI   = 6'h0F;
    localparam logic [5:0] OPC_LB    = 6'h20;
    localparam logic [5:0] OPC_LH    = 6'h21;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_LBU   = 6'h24;
    localparam logic [5:0] OPC_LHU   = 6'h25;
    localparam logic [5:0] OPC_SB    = 6'h28;
    localparam logic [5:0] OPC_SH    = 6'h29;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;

    localparam logic [2:0] LT_NONE = 3'd0;
    localparam logic [2:0] LT_LW   = 3'd1;
    localparam logic [2:0] LT_LH   = 3'd2;
    localparam logic [2:0] LT_LHU  = 3'd3;
    localparam logic [2:0] LT_LB   = 3'd4;
    localparam logic [2:0] LT_LBU  = 3'd5;

    localparam logic [1:0] TNEW_ALU  = 2'd0;
    localparam logic [1:0] TNEW_LOAD = 2'd1;

    typedef enum logic [4:0] {
        OP_NOP, OP_ADD, OP_SUB, OP_SLL, OP_JR, OP_ORI, OP_LUI, OP_JAL, OP_BEQ,
        OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB
    } op_e;

    typedef enum logic [1:0] {SZ_NONE, SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

    function automatic op_e decode_op(input logic [5:0] opc, input logic [5:0] fn);
        op_e op;
        op = OP_NOP;
        case (opc)
            OPC_RTYPE: begin
                case (fn)
                    FN_ADD:  op = OP_ADD;
                    FN_SUB:  op = OP_SUB;
                    FN_SLL:  op = OP_SLL;
                    FN_JR:   op = OP_JR;
                    default: op = OP_NOP;
                endcase
            end
            OPC_ORI: op = OP_ORI;
            OPC_LUI: op = OP_LUI;
            OPC_JAL: op = OP_JAL;
            OPC_BEQ: op = OP_BEQ;
            OPC_LW:  op = OP_LW;
            OPC_LH:  op = OP_LH;
            OPC_LHU: op = OP_LHU;
            OPC_LB:  op = OP_LB;
            OPC_LBU: op = OP_LBU;
            OPC_SW:  op = OP_SW;
            OPC_SH:  op = OP_SH;
            OPC_SB:  op = OP_SB;
            default: op = OP_NOP;
        endcase
        return op;
    endfunction

    function automatic logic is_load_op(input op_e op);
        return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
               (op == OP_LB) || (op == OP_LBU);
    endfunction

endpackage

// File: rtl/mem_lane_gen.sv
// Byte-lane generation for the data-memory port: byte enables, store-data
// replication across lanes, and natural-alignment checking.
module mem_lane_gen
    import mem_stage_ctrl_pkg::*;
#(
    parameter int  DATA_W = 32,
    localparam int BE_W   = DATA_W / 8,
    localparam int LANE_W = $clog2(BE_W)
) (
    input  logic [LANE_W-1:0] lane,
    input  size_e             size,
    input  logic              is_store,
    input  logic [DATA_W-1:0] src,
    output logic [BE_W-1:0]   be,
    output logic [DATA_W-1:0] wdata,
    output logic              misalign
);

    logic [LANE_W-1:0] half_base;
    logic [LANE_W-1:0] word_base;
    logic [BE_W-1:0]   be_raw;

    assign half_base = lane & ~LANE_W'(1);
    assign word_base = lane & ~LANE_W'(3);

    always_comb begin
        be_raw   = '0;
        wdata    = '0;
        misalign = 1'b0;
        case (size)
            SZ_BYTE: begin
                be_raw = BE_W'(1) << lane;
                wdata  = {BE_W{src[7:0]}};
            end
            SZ_HALF: begin
                be_raw   = BE_W'(3) << half_base;
                wdata    = {(BE_W/2){src[15:0]}};
                misalign = lane[0];
            end
            SZ_WORD: begin
                be_raw   = BE_W'(15) << word_base;
                wdata    = {(BE_W/4){src[31:0]}};
                misalign = |lane[1:0];
            end
            default: ;
        endcase
        // A misaligned store must not touch memory at all.
        be = (is_store && !misalign) ? be_raw : '0;
    end

endmodule

// File: rtl/mem_stage_ctrl.sv
// M-stage pipeline register and memory-access control: holds the instruction
// leaving E, decodes it, and drives the data-memory port and hazard info.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int  DATA_W = 32,
    parameter int  REG_AW = 5,
    localparam int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              stall,
    input  logic              flush,
    input  logic [31:0]       instr_e,
    input  logic [31:0]       pc_e,
    input  logic [DATA_W-1:0] alu_e,
    input  logic [DATA_W-1:0] rt_data_e,
    output logic [31:0]       instr_m,
    output logic [31:0]       pc_m,
    output logic              valid_m,
    output logic [REG_AW-1:0] reg_addr_m,
    output logic [1:0]        tnew_m,
    output logic              mem_we,
    output logic [BE_W-1:0]   mem_be,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [2:0]        load_type_m,
    output logic              addr_exc_m
);

    localparam int LANE_W = $clog2(BE_W);

    logic [DATA_W-1:0] alu_m;
    logic [DATA_W-1:0] store_m;
    op_e               op_in;
    op_e               op_m;
    size_e             acc_size;
    logic              is_store;
    logic              misalign;

    assign op_in = decode_op(instr_e[31:26], instr_e[5:0]);

    // ---- E -> M register boundary ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_m <= '0;
            pc_m    <= '0;
            valid_m <= 1'b0;
            tnew_m  <= TNEW_ALU;
            alu_m   <= '0;
            store_m <= '0;
        end else if (flush) begin
            instr_m <= '0;
            pc_m    <= '0;
            valid_m <= 1'b0;
            tnew_m  <= TNEW_ALU;
            alu_m   <= '0;
            store_m <= '0;
        end else if (!stall) begin
            instr_m <= instr_e;
            pc_m    <= pc_e;
            valid_m <= 1'b1;
            // W restarts its own countdown, so M keeps the entry value.
            tnew_m  <= is_load_op(op_in) ? TNEW_LOAD : TNEW_ALU;
            alu_m   <= alu_e;
            store_m <= rt_data_e;
        end
    end

    // ---- M-stage decode ----
    assign op_m = decode_op(instr_m[31:26], instr_m[5:0]);

    always_comb begin
        reg_addr_m  = '0;
        load_type_m = LT_NONE;
        acc_size    = SZ_NONE;
        is_store    = 1'b0;
        if (valid_m) begin
            case (op_m)
                OP_ADD, OP_SUB, OP_SLL: reg_addr_m = REG_AW'(instr_m[15:11]);
                OP_ORI, OP_LUI:         reg_addr_m = REG_AW'(instr_m[20:16]);
                OP_JAL:                 reg_addr_m = REG_AW'(5'd31);
                OP_LW: begin
                    reg_addr_m = REG_AW'(instr_m[20:16]);
                    load_type_m = LT_LW;
                    acc_size    = SZ_WORD;
                end
                OP_LH: begin
                    reg_addr_m = REG_AW'(instr_m[20:16]);
                    load_type_m = LT_LH;
                    acc_size    = SZ_HALF;
                end
                OP_LHU: begin
                    reg_addr_m = REG_AW'(instr_m[20:16]);
                    load_type_m = LT_LHU;
                    acc_size    = SZ_HALF;
                end
                OP_LB: begin
                    reg_addr_m = REG_AW'(instr_m[20:16]);
                    load_type_m = LT_LB;
                    acc_size    = SZ_BYTE;
                end
                OP_LBU: begin
                    reg_addr_m = REG_AW'(instr_m[20:16]);
                    load_type_m = LT_LBU;
                    acc_size    = SZ_BYTE;
                end
                OP_SW: begin acc_size = SZ_WORD; is_store = 1'b1; end
                OP_SH: begin acc_size = SZ_HALF; is_store = 1'b1; end
                OP_SB: begin acc_size = SZ_BYTE; is_store = 1'b1; end
                default: ;
            endcase
        end
    end

    mem_lane_gen #(.DATA_W(DATA_W)) u_lane (
        .lane     (alu_m[LANE_W-1:0]),
        .size     (acc_size),
        .is_store (is_store),
        .src      (store_m),
        .be       (mem_be),
        .wdata    (mem_wdata),
        .misalign (misalign)
    );

    assign mem_addr   = alu_m;
    assign addr_exc_m = valid_m & misalign;
    assign mem_we     = is_store & valid_m & ~addr_exc_m;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboarded bench for mem_stage_ctrl at DATA_W=32 and DATA_W=64 side by side,
// driven by directed cases and random traffic against a mnemonic-level model.
module tb_mem_stage_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] instr_e = '0;
    logic [31:0] pc_e = '0;
    logic [63:0] alu_in = '0;
    logic [63:0] rt_in = '0;

    logic [31:0] instr_a, pc_a, addr_a, wd_a;
    logic        valid_a, we_a, exc_a;
    logic [4:0]  rd_a;
    logic [1:0]  tnew_a;
    logic [3:0]  be_a;
    logic [2:0]  lt_a;

    logic [31:0] instr_b, pc_b;
    logic [63:0] addr_b, wd_b;
    logic        valid_b, we_b, exc_b;
    logic [4:0]  rd_b;
    logic [1:0]  tnew_b;
    logic [7:0]  be_b;
    logic [2:0]  lt_b;

    mem_stage_ctrl #(.DATA_W(32), .REG_AW(5)) dut32 (
        .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
        .instr_e(instr_e), .pc_e(pc_e), .alu_e(alu_in[31:0]), .rt_data_e(rt_in[31:0]),
        .instr_m(instr_a), .pc_m(pc_a), .valid_m(valid_a), .reg_addr_m(rd_a),
        .tnew_m(tnew_a), .mem_we(we_a), .mem_be(be_a), .mem_addr(addr_a),
        .mem_wdata(wd_a), .load_type_m(lt_a), .addr_exc_m(exc_a)
    );

    mem_stage_ctrl #(.DATA_W(64), .REG_AW(5)) dut64 (
        .clk(clk), .reset_n(reset_n), .stall(stall), .flush(flush),
        .instr_e(instr_e), .pc_e(pc_e), .alu_e(alu_in), .rt_data_e(rt_in),
        .instr_m(instr_b), .pc_m(pc_b), .valid_m(valid_b), .reg_addr_m(rd_b),
        .tnew_m(tnew_b), .mem_we(we_b), .mem_be(be_b), .mem_addr(addr_b),
        .mem_wdata(wd_b), .load_type_m(lt_b), .addr_exc_m(exc_b)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic [63:0] alu;
        logic [63:0] rt;
        logic        addr_known;
    } slot_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic [4:0]  rd;
        logic [1:0]  tnew;
        logic [2:0]  lt;
        logic        exc;
        logic        we;
        logic        addr_known;
        logic [63:0] addr;
        logic [3:0]  be32;
        logic [7:0]  be64;
        logic [31:0] wd32;
        logic [63:0] wd64;
    } exp_t;

    exp_t  sbq[$];
    slot_t slot = '{default: 0};

    function automatic string mnem(input logic [31:0] i);
        logic [5:0] op, fn;
        op = i[31:26];
        fn = i[5:0];
        case (op)
            6'h00: case (fn)
                       6'h20: return "add";
                       6'h22: return "sub";
                       6'h00: return "sll";
                       6'h08: return "jr";
                       default: return "nop";
                   endcase
            6'h0D: return "ori";
            6'h0F: return "lui";
            6'h03: return "jal";
            6'h04: return "beq";
            6'h23: return "lw";
            6'h21: return "lh";
            6'h25: return "lhu";
            6'h20: return "lb";
            6'h24: return "lbu";
            6'h2B: return "sw";
            6'h29: return "sh";
            6'h28: return "sb";
            default: return "nop";
        endcase
    endfunction

    function automatic int access_bytes(input string m);
        if (m == "lw" || m == "sw") return 4;
        if (m == "lh" || m == "lhu" || m == "sh") return 2;
        if (m == "lb" || m == "lbu" || m == "sb") return 1;
        return 0;
    endfunction

    function automatic logic [7:0] lanes(input logic [63:0] addr, input int sz, input int nb, input logic en);
        logic [7:0] r;
        int base;
        r = '0;
        if (en && sz > 0) begin
            base = (int'(addr % nb) / sz) * sz;
            for (int i = 0; i < nb; i++)
                if (i >= base && i < base + sz) r[i] = 1'b1;
        end
        return r;
    endfunction

    function automatic exp_t predict(input slot_t s);
        exp_t  e;
        string m;
        int    sz;
        logic  st, ld;
        m  = s.valid ? mnem(s.instr) : "nop";
        sz = access_bytes(m);
        st = (m == "sw" || m == "sh" || m == "sb");
        ld = (sz > 0) && !st;
        e.instr = s.instr;
        e.pc    = s.pc;
        e.valid = s.valid;
        if (m == "add" || m == "sub" || m == "sll") e.rd = s.instr[15:11];
        else if (ld || m == "ori" || m == "lui")    e.rd = s.instr[20:16];
        else if (m == "jal")                        e.rd = 5'd31;
        else                                        e.rd = 5'd0;
        e.tnew = ld ? 2'd1 : 2'd0;
        e.lt   = (m == "lw") ? 3'd1 : (m == "lh") ? 3'd2 : (m == "lhu") ? 3'd3 :
                 (m == "lb") ? 3'd4 : (m == "lbu") ? 3'd5 : 3'd0;
        e.exc  = (sz > 1) && ((s.alu % sz) != 0);
        e.we   = st && !e.exc;
        e.addr_known = s.addr_known;
        e.addr = s.alu;
        e.be32 = 4'(lanes(s.alu, sz, 4, e.we));
        e.be64 = lanes(s.alu, sz, 8, e.we);
        e.wd32 = '0;
        e.wd64 = '0;
        if (sz > 0) begin
            for (int i = 0; i < 4; i++) e.wd32[8*i +: 8] = s.rt[8*(i % sz) +: 8];
            for (int i = 0; i < 8; i++) e.wd64[8*i +: 8] = s.rt[8*(i % sz) +: 8];
        end
        return e;
    endfunction

    task automatic step(input logic [31:0] ins, input logic [63:0] alu, input logic [63:0] rt,
                        input logic st, input logic fl, input logic rstn);
        logic [31:0] pc;
        @(negedge clk);
        pc = $urandom;
        instr_e = ins; pc_e = pc; alu_in = alu; rt_in = rt;
        stall = st; flush = fl; reset_n = rstn;
        if (!rstn)    slot = '{default: 0, addr_known: 1'b1};
        else if (fl)  slot = '{instr: 32'd0, pc: 32'd0, valid: 1'b0, alu: 64'd0, rt: 64'd0, addr_known: 1'b0};
        else if (!st) slot = '{instr: ins, pc: pc, valid: 1'b1, alu: alu, rt: rt, addr_known: 1'b1};
        sbq.push_back(predict(slot));
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0]  rfn[4]  = '{6'h20, 6'h22, 6'h00, 6'h08};
        logic [5:0]  iop[12] = '{6'h0D, 6'h0F, 6'h03, 6'h04, 6'h23, 6'h21,
                                 6'h25, 6'h20, 6'h24, 6'h2B, 6'h29, 6'h28};
        logic [31:0] r;
        int k;
        k = $urandom_range(0, 17);
        r = $urandom;
        if (k < 4)       return {6'h00, r[25:6], rfn[k]};
        else if (k < 16) return {iop[k-4], r[25:0]};
        else if (k == 16) return {6'h00, r[25:6], 6'h3F};
        return r;
    endfunction

    // ---------------- monitor ----------------
    initial begin
        forever begin
            exp_t e;
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("instr_m", instr_a, e.instr);
                chk("pc_m", pc_a, e.pc);
                chk("valid_m", valid_a, e.valid);
                chk("reg_addr_m", rd_a, e.rd);
                chk("tnew_m", tnew_a, e.tnew);
                chk("load_type_m", lt_a, e.lt);
                chk("addr_exc_m", exc_a, e.exc);
                chk("mem_we", we_a, e.we);
                chk("mem_be", be_a, e.be32);
                chk("valid_m64", valid_b, e.valid);
                chk("reg_addr_m64", rd_b, e.rd);
                chk("tnew_m64", tnew_b, e.tnew);
                chk("addr_exc_m64", exc_b, e.exc);
                chk("mem_we64", we_b, e.we);
                chk("mem_be64", be_b, e.be64);
                if (e.addr_known) begin
                    chk("mem_addr", addr_a, e.addr[31:0]);
                    chk("mem_addr64", addr_b, e.addr);
                end
                if (e.we) begin
                    chk("mem_wdata", wd_a, e.wd32);
                    chk("mem_wdata64", wd_b, e.wd64);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    localparam logic [31:0] SW_R9 = {6'h2B, 5'd4, 5'd9, 16'h0000};
    localparam logic [31:0] SB_R9 = {6'h28, 5'd4, 5'd9, 16'h0000};
    localparam logic [31:0] SH_R9 = {6'h29, 5'd4, 5'd9, 16'h0000};
    localparam logic [31:0] LW_R8 = {6'h23, 5'd4, 5'd8, 16'h0010};
    localparam logic [31:0] ADD_3 = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20};
    localparam logic [31:0] JAL_X = {6'h03, 26'h0000100};

    initial begin
        logic rst_now;
        logic [63:0] a, d;

        repeat (3) step(SW_R9, 64'h1000, 64'h55, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("reset_we", we_a, 1'b0);
        chk("reset_reg_addr", rd_a, 5'd0);
        chk("reset_valid", valid_a, 1'b0);

        step(SB_R9, 64'h1003, 64'h0000_00AB, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("sb_be", be_a, 4'b1000);
        chk("sb_wdata", wd_a, 32'hABAB_ABAB);
        chk("sb_we", we_a, 1'b1);

        step(SH_R9, 64'h1001, 64'h1234, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("sh_mis_exc", exc_a, 1'b1);
        chk("sh_mis_we", we_a, 1'b0);
        chk("sh_mis_be", be_a, 4'b0000);

        step(LW_R8, 64'h2000, 64'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) step(ADD_3, 64'h3001, 64'h7, 1'b1, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("lw_stall_rd", rd_a, 5'd8);
        chk("lw_stall_tnew", tnew_a, 2'd1);
        chk("lw_stall_lt", lt_a, 3'd1);

        step(JAL_X, 64'h0, 64'h0, 1'b1, 1'b1, 1'b1);
        @(posedge clk); #1;
        chk("flush_stall_valid", valid_a, 1'b0);
        chk("flush_stall_rd", rd_a, 5'd0);
        step(JAL_X, 64'h0, 64'h0, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("jal_rd", rd_a, 5'd31);
        chk("jal_tnew", tnew_a, 2'd0);

        step(SW_R9, 64'h1004, 64'hDEAD_BEEF_1122_3344, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("sw64_be", be_b, 8'hF0);
        chk("sw64_wdata", wd_b, 64'h1122_3344_1122_3344);

        // reset asserted while stalled, then released
        step(ADD_3, 64'h10, 64'h1, 1'b1, 1'b0, 1'b0);
        step(SW_R9, 64'h1008, 64'h99, 1'b1, 1'b0, 1'b1);
        step(SW_R9, 64'h1008, 64'h99, 1'b0, 1'b0, 1'b1);

        for (int n = 0; n < 500; n++) begin
            rst_now = ($urandom_range(0, 49) == 0);
            a = {$urandom, $urandom};
            d = {$urandom, $urandom};
            step(rand_instr(), a, d, ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 9) == 0), !rst_now);
        end

        @(posedge clk); #2;
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
